video_in_capture: RTL and testbench
===================================

// Module: video_in_capture
// PURPOSE
//  Receiving end of the video stream protocol (pixel_in / frame_valid / line_valid on pixel clock clk_in).
//  Samples the stream in the clk domain, packs 4 pixels per 32-bit word, writes words to the input FIFO.
//  Checks frame geometry. Drops the rest of a frame on FIFO overflow. Sits between camera/video source and the input FIFO.
// PARAMETERS
//  WIDTH   640  pixels per line; must be a multiple of 4
//  HEIGHT  480  lines per frame
// PORTS
//  clk          in   1   system clock; period must not exceed 1/4 of the clk_in period
//  nRST         in   1   asynchronous, active-low reset
//  clk_in       in   1   pixel clock; sampled as data, never used as a clock
//  pixel_in     in   8   pixel, valid when frame_valid & line_valid
//  frame_valid  in   1   high for the whole frame, including line breaks
//  line_valid   in   1   high during active pixels of a line
//  w_req        out  1   FIFO write strobe, one clk cycle per word
//  w_data       out  32  packed word; pixel 0 in [7:0], pixel 3 in [31:24]
//  fifo_full    in   1   FIFO cannot accept a write this cycle
//  clr_err      in   1   clears the sticky error flags
//  frame_done   out  1   1-cycle pulse on falling edge of frame_valid while in a frame
//  frame_ok     out  1   qualifies frame_done: frame had correct geometry and no drop
//  err_geom     out  1   sticky: line length != WIDTH or line count != HEIGHT
//  err_ovf      out  1   sticky: word lost because fifo_full
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters, pack register and sync flops cleared.
//  - Sampling:
//    - clk_in, frame_valid, line_valid and pixel_in pass through 2 flip-flops in the clk domain.
//    - A sample event (tick) is a synchronized clk_in 0->1 transition.
//    - On tick, the synchronized pixel/fv/lv are the current sample.
//    - Edges of fv/lv are evaluated between consecutive ticks only.
//  - States:
//    - IDLE: wait for sampled fv=0 -> ARM. Reset mid-frame therefore never captures a partial frame.
//    - ARM: fv 0->1 -> FRAME; clear line_cnt, pix_cnt, frame error bit.
//    - FRAME: lv=1 at a tick -> capture the pixel if pix_cnt < WIDTH, then pix_cnt++. Pixels past WIDTH are ignored.
//      - lv 1->0 with pix_cnt != WIDTH -> err_geom=1, frame marked bad; the partial word is discarded.
//      - Every lv 1->0 -> line_cnt++ (saturating at 1023), pix_cnt=0.
//      - Lines beyond HEIGHT are not written.
//      - fv 1->0 -> frame_done pulse. frame_ok = (line_cnt==HEIGHT) & frame not bad; then -> ARM.
//        fv falling while lv=1 closes the line first.
//    - DROP: entered when a word is complete while fifo_full=1.
//      - The word is lost; err_ovf=1; frame marked bad; no further writes.
//      - fv 1->0 -> frame_done with frame_ok=0 -> ARM.
//  - Write latency: w_req and w_data are registered, asserted the clk cycle after the tick holding the 4th pixel.
//  - w_req is never asserted when fifo_full was high in that same decision cycle.
//  - Counters: pix_cnt and line_cnt are 10 bits. No wrap inside valid geometry.
//  - Errors: clr_err clears err_geom and err_ovf. A set event in the same cycle as clr_err wins.
// CONFIGURATION
//  VIDEO_IN_STATS_EN defined:
//    - Adds outputs frame_cnt[15:0] (frame_done & frame_ok) and drop_cnt[15:0] (frames ended in DROP).
//    - Both wrap at 16 bits and reset to 0; clr_err does not clear them.
//  VIDEO_IN_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package video_pkg:
//    - typedef pixel_t (logic [7:0])
//    - enum vin_state_t {IDLE, ARM, FRAME, DROP}
//    - localparam PIX_PER_WORD=4
//    - localparam default geometry 640x480
//  Sub-module clk_edge_sync: 2-flop synchronizer plus rising-edge detector, output tick. Instantiated once for clk_in.
//  Capture FSM, pack register and counters stay in video_in_capture.
// TESTING
//  1. Nominal frame:
//     - Stimulus: WIDTH=8, HEIGHT=2, clk_in=clk/4, pixels 0..15.
//     - Expect: 4 writes 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; frame_done=1 with frame_ok=1.
//  2. Short line:
//     - Stimulus: line 1 has 6 pixels.
//     - Expect: err_geom=1; only 1 word written for that line; frame_ok=0. clr_err -> err_geom=0.
//  3. Overflow:
//     - Stimulus: fifo_full=1 during the 2nd word of a frame.
//     - Expect: err_ovf=1; no w_req until the next frame. Next clean frame gives frame_ok=1. drop_cnt=1 with STATS.
//  4. Reset mid-frame:
//     - Stimulus: nRST pulsed during line 1 while fv is still high.
//     - Expect: no w_req until fv falls, then rises again; the following frame is captured fully.
//  5. Extra line:
//     - Stimulus: HEIGHT+1 lines.
//     - Expect: 4 words only (WIDTH=8, HEIGHT=2); err_geom=1; frame_ok=0.
//  6. STATS build:
//     - Stimulus: 3 good frames.
//     - Expect: frame_cnt=3. Without the macro, the bench compiles without the stats ports.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and constants for the video input capture block.
package video_pkg;

   typedef logic [7:0] pixel_t;

   typedef enum logic [1:0] {IDLE, ARM, FRAME, DROP} vin_state_t;

   localparam int PIX_PER_WORD = 4;
   localparam int WORD_W       = PIX_PER_WORD * 8;
   localparam int DEF_WIDTH    = 640;
   localparam int DEF_HEIGHT   = 480;
   localparam int CNT_W        = 10;

endpackage

// File: rtl/video_in_capture_if.sv
// Pixel stream in, packed FIFO write out. master = capture block, slave = source/FIFO side.
interface video_in_capture_if;
   import video_pkg::*;

   logic                clk_in;
   pixel_t              pixel_in;
   logic                frame_valid;
   logic                line_valid;
   logic                w_req;
   logic [WORD_W-1:0]   w_data;
   logic                fifo_full;

   modport master (
      input  clk_in, pixel_in, frame_valid, line_valid, fifo_full,
      output w_req, w_data
   );

   modport slave (
      output clk_in, pixel_in, frame_valid, line_valid, fifo_full,
      input  w_req, w_data
   );

endinterface

// File: rtl/clk_edge_sync.sv
// Two-flop synchronizer with rising-edge detect; o_tick is a one-cycle pulse per 0->1 of i_async.
module clk_edge_sync (
   input  logic clk,
   input  logic nRST,
   input  logic i_async,
   output logic o_tick
);

   logic r_s1, r_s2, r_prev;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_s1   <= i_async;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   assign o_tick = r_s2 & ~r_prev;

endmodule

// File: rtl/video_in_capture.sv
// Samples pixel stream in clk domain, packs 4 pixels/word into the input FIFO, checks geometry.
// Optional VIDEO_IN_STATS_EN adds frame_cnt / drop_cnt outputs.
module video_in_capture
   import video_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT
) (
   input  logic               clk,
   input  logic               nRST,
   video_in_capture_if.master vif,
   input  logic               clr_err,
   output logic               frame_done,
   output logic               frame_ok,
   output logic               err_geom,
   output logic               err_ovf
`ifdef VIDEO_IN_STATS_EN
   ,
   output logic [15:0]        frame_cnt,
   output logic [15:0]        drop_cnt
`endif
);

   localparam logic [CNT_W-1:0] W_CNT   = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] H_CNT   = CNT_W'(HEIGHT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // fv/lv/pixel share the synchronizer depth of clk_in so they line up with the tick
   logic [9:0]          r_sync1, r_sync2;
   logic                w_tick, w_fv, w_lv;
   pixel_t              w_pix;

   vin_state_t          r_state, w_state_nx;
   logic                r_fv_prev, r_lv_prev;
   logic [CNT_W-1:0]    r_pix_cnt, r_line_cnt, w_pix_cnt_nx, w_line_cnt_nx;
   logic                r_bad, w_bad_nx;
   logic [WORD_W-1:0]   r_pack, w_pack_nx;

   logic                r_w_req, r_frame_done, r_frame_ok, r_err_geom, r_err_ovf;
   logic [WORD_W-1:0]   r_w_data;
   logic                w_fv_rise, w_fv_fall, w_close;
   logic                w_wr, w_done, w_ok, w_drop_end, w_set_geom, w_set_ovf;

   clk_edge_sync u_clk_sync (
      .clk     (clk),
      .nRST    (nRST),
      .i_async (vif.clk_in),
      .o_tick  (w_tick)
   );

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {vif.line_valid, vif.frame_valid, vif.pixel_in};
         r_sync2 <= r_sync1;
      end
   end

   assign w_pix     = r_sync2[7:0];
   assign w_fv      = r_sync2[8];
   assign w_lv      = r_sync2[9];
   assign w_fv_rise = w_fv & ~r_fv_prev;
   assign w_fv_fall = ~w_fv & r_fv_prev;
   // fv dropping while lv is still high ends the line as well
   assign w_close   = r_lv_prev & (~w_lv | ~w_fv);

   always_comb begin
      w_state_nx    = r_state;
      w_pix_cnt_nx  = r_pix_cnt;
      w_line_cnt_nx = r_line_cnt;
      w_bad_nx      = r_bad;
      w_pack_nx     = r_pack;
      w_wr          = 1'b0;
      w_done        = 1'b0;
      w_ok          = 1'b0;
      w_drop_end    = 1'b0;
      w_set_geom    = 1'b0;
      w_set_ovf     = 1'b0;
      if (w_tick) begin
         case (r_state)
            IDLE: if (!w_fv) w_state_nx = ARM;
            ARM: if (w_fv_rise) begin
               w_state_nx    = FRAME;
               w_pix_cnt_nx  = '0;
               w_line_cnt_nx = '0;
               w_bad_nx      = 1'b0;
            end
            FRAME: begin
               if (w_close) begin
                  if (r_pix_cnt != W_CNT) begin
                     w_set_geom = 1'b1;
                     w_bad_nx   = 1'b1;
                  end
                  if (r_line_cnt != CNT_MAX) w_line_cnt_nx = r_line_cnt + 1'b1;
                  w_pix_cnt_nx = '0;
               end else if (w_lv && w_fv) begin
                  if (r_pix_cnt < W_CNT && r_line_cnt < H_CNT) begin
                     w_pack_nx[{r_pix_cnt[1:0], 3'b000} +: 8] = w_pix;
                     if (r_pix_cnt[1:0] == 2'd3) begin
                        if (vif.fifo_full) begin
                           w_set_ovf  = 1'b1;
                           w_bad_nx   = 1'b1;
                           w_state_nx = DROP;
                        end else begin
                           w_wr = 1'b1;
                        end
                     end
                  end
                  if (r_pix_cnt != CNT_MAX) w_pix_cnt_nx = r_pix_cnt + 1'b1;
               end
               if (w_fv_fall) begin
                  if (w_line_cnt_nx != H_CNT) begin
                     w_set_geom = 1'b1;
                     w_bad_nx   = 1'b1;
                  end
                  w_done     = 1'b1;
                  w_ok       = ~w_bad_nx;
                  w_state_nx = ARM;
               end
            end
            DROP: if (w_fv_fall) begin
               w_done     = 1'b1;
               w_drop_end = 1'b1;
               w_state_nx = ARM;
            end
            default: w_state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_state      <= IDLE;
         r_fv_prev    <= 1'b0;
         r_lv_prev    <= 1'b0;
         r_pix_cnt    <= '0;
         r_line_cnt   <= '0;
         r_bad        <= 1'b0;
         r_pack       <= '0;
         r_w_req      <= 1'b0;
         r_w_data     <= '0;
         r_frame_done <= 1'b0;
         r_frame_ok   <= 1'b0;
         r_err_geom   <= 1'b0;
         r_err_ovf    <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_pix_cnt    <= w_pix_cnt_nx;
         r_line_cnt   <= w_line_cnt_nx;
         r_bad        <= w_bad_nx;
         r_pack       <= w_pack_nx;
         r_w_req      <= w_wr;
         r_frame_done <= w_done;
         r_frame_ok   <= w_done & w_ok;
         if (w_tick) begin
            r_fv_prev <= w_fv;
            r_lv_prev <= w_lv;
         end
         if (w_wr) r_w_data <= w_pack_nx;
         // a set in the same cycle as clr_err takes priority
         if (w_set_geom)   r_err_geom <= 1'b1;
         else if (clr_err) r_err_geom <= 1'b0;
         if (w_set_ovf)    r_err_ovf  <= 1'b1;
         else if (clr_err) r_err_ovf  <= 1'b0;
      end
   end

   assign vif.w_req  = r_w_req;
   assign vif.w_data = r_w_data;
   assign frame_done = r_frame_done;
   assign frame_ok   = r_frame_ok;
   assign err_geom   = r_err_geom;
   assign err_ovf    = r_err_ovf;

`ifdef VIDEO_IN_STATS_EN
   logic [15:0] r_frame_cnt, r_drop_cnt;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_frame_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         if (w_done && w_ok) r_frame_cnt <= r_frame_cnt + 16'd1;
         if (w_drop_end)     r_drop_cnt  <= r_drop_cnt + 16'd1;
      end
   end

   assign frame_cnt = r_frame_cnt;
   assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_video_in_capture.sv
// Bench for video_in_capture (WIDTH=8, HEIGHT=2) with a frame-level reference model.
module tb_video_in_capture;
   import video_pkg::*;

   localparam int W = 8;
   localparam int H = 2;

   logic clk = 1'b0;
   logic clk_in_r = 1'b0;
   logic nRST, clr_err;
   logic frame_done, frame_ok, err_geom, err_ovf;
`ifdef VIDEO_IN_STATS_EN
   logic [15:0] frame_cnt, drop_cnt;
`endif

   video_in_capture_if bus ();

   video_in_capture #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk        (clk),
      .nRST       (nRST),
      .vif        (bus),
      .clr_err    (clr_err),
      .frame_done (frame_done),
      .frame_ok   (frame_ok),
      .err_geom   (err_geom),
      .err_ovf    (err_ovf)
`ifdef VIDEO_IN_STATS_EN
      ,
      .frame_cnt  (frame_cnt),
      .drop_cnt   (drop_cnt)
`endif
   );

   always #5 clk = ~clk;
   always #20 clk_in_r = ~clk_in_r;
   assign bus.clk_in = clk_in_r;

   int checks = 0;
   int failures = 0;

   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];
   bit          done_q[$];

   int          nlines;
   int          lens[8];
   logic [7:0]  pix[8][16];
   int          exp_good = 0;
   int          exp_drop = 0;

   always @(negedge clk) begin
      if (bus.w_req) got_q.push_back(bus.w_data);
      if (frame_done) done_q.push_back(frame_ok);
   end

   task automatic pulse_clr();
      @(negedge clk) clr_err = 1'b1;
      @(negedge clk) clr_err = 1'b0;
   endtask

   // drives one frame on clk_in falling edges; fifo_full rises while word drop_word is being filled
   task automatic drive_frame(input int drop_word, input bit seq);
      int wpix = 0;
      int seqv = 0;
      @(negedge bus.clk_in);
      bus.frame_valid = 1'b1;
      bus.line_valid  = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge bus.clk_in);
      for (int l = 0; l < nlines; l++) begin
         for (int p = 0; p < lens[l]; p++) begin
            logic [7:0] v;
            @(negedge bus.clk_in);
            v = seq ? 8'(seqv) : 8'($urandom);
            seqv++;
            pix[l][p] = v;
            bus.pixel_in   = v;
            bus.line_valid = 1'b1;
            if (l < H && p < W) begin
               if (drop_word >= 0 && wpix == drop_word * 4 + 1) bus.fifo_full = 1'b1;
               wpix++;
            end
         end
         @(negedge bus.clk_in);
         bus.line_valid = 1'b0;
         bus.pixel_in   = 8'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge bus.clk_in);
      end
      @(negedge bus.clk_in);
      bus.frame_valid = 1'b0;
      repeat (4) @(negedge bus.clk_in);
      bus.fifo_full = 1'b0;
   endtask

   // reference: whole words of the first WIDTH pixels of the first HEIGHT lines, cut at a lost word
   task automatic model_frame(input int drop_word, output bit ok, output bit geom, output bit dropped);
      int wcnt = 0;
      dropped = 1'b0;
      geom = (nlines != H);
      for (int l = 0; l < nlines; l++) begin
         if (lens[l] != W) geom = 1'b1;
         if (l < H) begin
            for (int w = 0; w < ((lens[l] < W) ? lens[l] : W) / 4; w++) begin
               if (wcnt == drop_word) dropped = 1'b1;
               if (!dropped)
                  exp_q.push_back({pix[l][4*w+3], pix[l][4*w+2], pix[l][4*w+1], pix[l][4*w]});
               wcnt++;
            end
         end
      end
      if (dropped) geom = 1'b0;
      ok = !geom && !dropped;
      if (ok) exp_good++;
      if (dropped) exp_drop++;
   endtask

   task automatic run_frame(input int drop_word, input bit seq, output bit ok, output bit geom,
                            output bit dropped);
      pulse_clr();
      got_q.delete();
      exp_q.delete();
      done_q.delete();
      drive_frame(drop_word, seq);
      model_frame(drop_word, ok, geom, dropped);
      repeat (12) @(posedge clk);
   endtask

   function automatic int word_errs();
      int n = (got_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) n++;
      return n;
   endfunction

   task automatic test_reset();
      nRST = 1'b0; clr_err = 1'b0;
      bus.pixel_in = '0; bus.frame_valid = 1'b0; bus.line_valid = 1'b0; bus.fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.w_req, frame_done, frame_ok, err_geom, err_ovf} !== 5'b0 || bus.w_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs got req=%b data=%h done=%b ok=%b eg=%b eo=%b want all 0",
                  bus.w_req, bus.w_data, frame_done, frame_ok, err_geom, err_ovf);
      end
      nRST = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if ({bus.w_req, frame_done, err_geom, err_ovf} !== 4'b0) begin
         failures++;
         $display("FAIL idle_after_reset got req=%b done=%b eg=%b eo=%b want 0",
                  bus.w_req, frame_done, err_geom, err_ovf);
      end
`ifdef VIDEO_IN_STATS_EN
      checks++;
      if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_stats got %0d/%0d want 0/0", frame_cnt, drop_cnt);
      end
`endif
   endtask

   task automatic test_nominal();
      bit ok, geom, dr;
      nlines = 2; lens[0] = 8; lens[1] = 8;
      run_frame(-1, 1'b1, ok, geom, dr);
      checks++;
      if (got_q.size() != 4 || got_q[0] !== 32'h03020100 || got_q[1] !== 32'h07060504 ||
          got_q[2] !== 32'h0B0A0908 || got_q[3] !== 32'h0F0E0D0C) begin
         failures++;
         $display("FAIL nominal_words got n=%0d first=%h last=%h want 4 words 03020100..0F0E0D0C",
                  got_q.size(), got_q[0], got_q[got_q.size()-1]);
      end
      checks++;
      if (done_q.size() != 1 || done_q[0] !== 1'b1) begin
         failures++;
         $display("FAIL nominal_done got n=%0d ok=%b want 1 done with ok=1", done_q.size(), done_q[0]);
      end
      checks++;
      if (err_geom !== 1'b0 || err_ovf !== 1'b0) begin
         failures++;
         $display("FAIL nominal_errs got eg=%b eo=%b want 0/0", err_geom, err_ovf);
      end
   endtask

   task automatic test_short_line();
      bit ok, geom, dr;
      nlines = 2; lens[0] = 8; lens[1] = 6;
      run_frame(-1, 1'b0, ok, geom, dr);
      checks++;
      if (word_errs() != 0 || got_q.size() != 3) begin
         failures++;
         $display("FAIL short_words got n=%0d errs=%0d want 3 matching", got_q.size(), word_errs());
      end
      checks++;
      if (err_geom !== 1'b1 || done_q.size() != 1 || done_q[0] !== 1'b0) begin
         failures++;
         $display("FAIL short_flags got eg=%b ndone=%0d ok=%b want eg=1 1 done ok=0",
                  err_geom, done_q.size(), done_q[0]);
      end
      pulse_clr();
      @(negedge clk);
      checks++;
      if (err_geom !== 1'b0) begin
         failures++;
         $display("FAIL short_clr got eg=%b want 0", err_geom);
      end
   endtask

   task automatic test_overflow();
      bit ok, geom, dr;
      nlines = 2; lens[0] = 8; lens[1] = 8;
      run_frame(1, 1'b0, ok, geom, dr);
      checks++;
      if (word_errs() != 0 || got_q.size() != 1) begin
         failures++;
         $display("FAIL ovf_words got n=%0d errs=%0d want 1 matching", got_q.size(), word_errs());
      end
      checks++;
      if (err_ovf !== 1'b1 || done_q.size() != 1 || done_q[0] !== 1'b0) begin
         failures++;
         $display("FAIL ovf_flags got eo=%b ndone=%0d ok=%b want eo=1 1 done ok=0",
                  err_ovf, done_q.size(), done_q[0]);
      end
      run_frame(-1, 1'b0, ok, geom, dr);
      checks++;
      if (word_errs() != 0 || done_q.size() != 1 || done_q[0] !== ok || err_ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_recover got errs=%0d ndone=%0d ok=%b eo=%b want 0 1 %b 0",
                  word_errs(), done_q.size(), done_q[0], err_ovf, ok);
      end
   endtask

   task automatic test_reset_mid();
      bit ok, geom, dr;
      nlines = 2; lens[0] = 8; lens[1] = 8;
      pulse_clr();
      got_q.delete(); exp_q.delete(); done_q.delete();
      fork
         drive_frame(-1, 1'b0);
         begin
            repeat (6) @(negedge bus.clk_in);
            @(negedge clk) nRST = 1'b0;
            repeat (2) @(negedge clk);
            nRST = 1'b1;
         end
      join
      exp_good = 0; exp_drop = 0;
      repeat (12) @(posedge clk);
      checks++;
      if (got_q.size() != 0 || done_q.size() != 0) begin
         failures++;
         $display("FAIL midreset_partial got words=%0d dones=%0d want 0/0", got_q.size(), done_q.size());
      end
      run_frame(-1, 1'b0, ok, geom, dr);
      checks++;
      if (word_errs() != 0 || got_q.size() != 4 || done_q.size() != 1 || done_q[0] !== 1'b1) begin
         failures++;
         $display("FAIL midreset_next got n=%0d errs=%0d ndone=%0d ok=%b want 4 0 1 1",
                  got_q.size(), word_errs(), done_q.size(), done_q[0]);
      end
   endtask

   task automatic test_extra_line();
      bit ok, geom, dr;
      nlines = 3; lens[0] = 8; lens[1] = 8; lens[2] = 8;
      run_frame(-1, 1'b0, ok, geom, dr);
      checks++;
      if (word_errs() != 0 || got_q.size() != 4) begin
         failures++;
         $display("FAIL extra_words got n=%0d errs=%0d want 4 matching", got_q.size(), word_errs());
      end
      checks++;
      if (err_geom !== 1'b1 || done_q.size() != 1 || done_q[0] !== 1'b0) begin
         failures++;
         $display("FAIL extra_flags got eg=%b ndone=%0d ok=%b want 1 1 0", err_geom, done_q.size(), done_q[0]);
      end
   endtask

   task automatic test_random();
      bit ok, geom, dr;
      int choice[4] = '{W, W, W - 2, W + 2};
      for (int f = 0; f < 6; f++) begin
         nlines = $urandom_range(1, 3);
         for (int l = 0; l < nlines; l++) lens[l] = choice[$urandom_range(0, 3)];
         run_frame(-1, 1'b0, ok, geom, dr);
         checks++;
         if (word_errs() != 0 || done_q.size() != 1 || done_q[0] !== ok || err_geom !== geom) begin
            failures++;
            $display("FAIL random_frame%0d got n=%0d errs=%0d ndone=%0d ok=%b eg=%b want n=%0d ok=%b eg=%b",
                     f, got_q.size(), word_errs(), done_q.size(), done_q[0], err_geom,
                     exp_q.size(), ok, geom);
         end
      end
   endtask

   task automatic test_stats();
      bit ok, geom, dr;
      for (int f = 0; f < 3; f++) begin
         nlines = 2; lens[0] = 8; lens[1] = 8;
         run_frame(-1, 1'b0, ok, geom, dr);
         checks++;
         if (word_errs() != 0 || done_q.size() != 1 || done_q[0] !== 1'b1) begin
            failures++;
            $display("FAIL stats_frame%0d got errs=%0d ndone=%0d ok=%b want 0 1 1",
                     f, word_errs(), done_q.size(), done_q[0]);
         end
      end
`ifdef VIDEO_IN_STATS_EN
      checks++;
      if (frame_cnt !== 16'(exp_good) || drop_cnt !== 16'(exp_drop)) begin
         failures++;
         $display("FAIL stats_counts got frame=%0d drop=%0d want %0d/%0d", frame_cnt, drop_cnt, exp_good, exp_drop);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_short_line();
      test_overflow();
`ifdef VIDEO_IN_STATS_EN
      checks++;
      if (drop_cnt !== 16'd1) begin
         failures++;
         $display("FAIL stats_drop got %0d want 1", drop_cnt);
      end
`endif
      test_reset_mid();
      test_extra_line();
      test_random();
      test_stats();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
